// File: rtl/dmem_ctrl.sv
// Data-memory controller for the pipelined MIPS core: word-organised RAM behind a
// request/done handshake with wait states, sub-word access and error reporting.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t            state_r, state_s;
    logic [3:0]        cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        size_r;
    logic              we_r, uns_r;
    logic [31:0]       wdata_r;
    logic [31:0]       mem_r [DEPTH_WORDS];

    logic              capture_s, commit_s, illegal_s, done_s, busy_s;
    logic [3:0]        be_s;
    logic [31:0]       wlane_s, word_s, load_s;
    logic [IDX_W-1:0]  idx_s;

    // Out-of-range or misaligned accesses, plus the reserved size code, are illegal.
    function automatic logic is_illegal(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
        logic oor;
        oor = ({1'b0, a} >= (ADDR_W+1)'(4 * DEPTH_WORDS));
        case (sz)
            2'b00:   is_illegal = oor;
            2'b01:   is_illegal = oor | a[0];
            2'b10:   is_illegal = oor | (a[1:0] != 2'b00);
            default: is_illegal = 1'b1;
        endcase
    endfunction

    // Pick the addressed lanes out of a word and extend them to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] lane, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lane, 3'b000});
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   extract = u ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   extract = u ? {16'd0, h} : {{16{h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    assign capture_s = req && ((state_r == IDLE) || (state_r == RESP));
    assign commit_s  = (state_r == BUSY) && (cnt_r == 4'd0);
    assign illegal_s = is_illegal(size_r, addr_r);
    assign idx_s     = addr_r[IDX_W+1:2];
    assign word_s    = mem_r[idx_s];
    assign load_s    = extract(word_s, size_r, addr_r[1:0], uns_r);

    // Byte enables and lane-replicated store data.
    always_comb begin
        be_s    = 4'b0000;
        wlane_s = wdata_r;
        case (size_r)
            2'b00: begin
                be_s    = 4'b0001 << addr_r[1:0];
                wlane_s = {4{wdata_r[7:0]}};
            end
            2'b01: begin
                be_s    = addr_r[1] ? 4'b1100 : 4'b0011;
                wlane_s = {2{wdata_r[15:0]}};
            end
            2'b10:   be_s = 4'b1111;
            default: be_s = 4'b0000;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; requests arriving while BUSY are ignored.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = req ? BUSY : IDLE;
            BUSY:    state_s = commit_s ? RESP : BUSY;
            RESP:    state_s = req ? BUSY : IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode from the next state so done/busy can be registered in step with it.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            BUSY:    busy_s = 1'b1;
            RESP:    done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Request capture, wait-state counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r   <= 4'd0;
            addr_r  <= '0;
            size_r  <= 2'b00;
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            wdata_r <= 32'd0;
            rdata   <= 32'd0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= done_s;
            busy <= busy_s;
            err  <= commit_s & illegal_s;
            if (capture_s) begin
                cnt_r   <= 4'(WAIT_STATES);
                addr_r  <= addr;
                size_r  <= size;
                we_r    <= we;
                uns_r   <= uns;
                wdata_r <= wdata;
            end else if ((state_r == BUSY) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            // Stores leave rdata untouched; illegal accesses force it to zero.
            if (commit_s) begin
                if (illegal_s) begin
                    rdata <= 32'd0;
                end else if (!we_r) begin
                    rdata <= load_s;
                end
            end
        end
    end

    // RAM array is not reset; a reset during BUSY drops the commit via state_r.
    always_ff @(posedge clk) begin
        if (commit_s && we_r && !illegal_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: one instance with no wait states and
// one with three wait states, sharing clock, reset and request fields.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req3, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata0, rdata3;
    logic        done0, err0, busy0, done3, err3, busy3;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] rd;
    logic        er;
    int          lat, bc, dc, d1, d2, nd;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(64), .ADDR_W(32), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .done(done0), .err(err0), .busy(busy0));

    dmem_ctrl #(.DEPTH_WORDS(64), .ADDR_W(32), .WAIT_STATES(3)) u3 (
        .clk(clk), .reset(reset), .req(req3), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .rdata(rdata3), .done(done3), .err(err3), .busy(busy3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access; lat counts negedges from request to the first done (30 = timed out).
    task automatic access(input bit s3, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        we = w; size = sz; uns = u; addr = a; wdata = d;
        if (s3) req3 = 1'b1; else req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0; req3 = 1'b0;
        lat = 1;
        while (!(s3 ? done3 : done0) && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        rd = s3 ? rdata3 : rdata0;
        er = s3 ? err3 : err0;
    endtask

    initial begin
        reset = 1'b0; req0 = 1'b0; req3 = 1'b0; we = 1'b0; uns = 1'b0;
        size = 2'b00; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_out0", {rdata0[31:3], done0, err0, busy0}, 32'd0);
        chk("rst_out3", {rdata3[31:3], done3, err3, busy3}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h8765_4321);
        chk("st_word_lat", 32'(lat), 32'd2);
        chk("st_word_err", {31'd0, er}, 32'd0);
        chk("st_word_rdata", rd, 32'd0);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        chk("ld_word", rd, 32'h8765_4321);
        chk("ld_word_lat", 32'(lat), 32'd2);
        chk("ld_word_err", {31'd0, er}, 32'd0);

        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
        chk("ld_byte_s", rd, 32'hFFFF_FF87);
        access(1'b0, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
        chk("ld_byte_u", rd, 32'h0000_0087);
        access(1'b0, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
        chk("ld_half_s", rd, 32'hFFFF_8765);
        access(1'b0, 1'b0, 2'b01, 1'b1, 32'h10, 32'd0);
        chk("ld_half_u", rd, 32'h0000_4321);

        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_56AA);
        chk("st_byte_keeps_rdata", rd, 32'h0000_4321);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        chk("merge_byte", rd, 32'h8765_AA21);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_BEEF);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        chk("merge_half", rd, 32'hBEEF_AA21);

        // Illegal stores of all-ones; none may disturb word 0x10.
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFF_FFFF);
        chk("err_word_mis", {rd[31:1], er}, 32'd1);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF_FFFF);
        chk("err_half_mis", {rd[31:1], er}, 32'd1);
        access(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF);
        chk("err_size11", {rd[31:1], er}, 32'd1);
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h110, 32'hFFFF_FFFF);
        chk("err_range_st", {rd[31:1], er}, 32'd1);
        chk("err_done_lat", 32'(lat), 32'd2);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        chk("err_mem_kept", rd, 32'hBEEF_AA21);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        chk("err_range_ld_rdata", rd, 32'd0);
        chk("err_range_ld_err", {31'd0, er}, 32'd1);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'd0);
        chk("err_cleared", {31'd0, er}, 32'd0);

        // Three wait states: busy for 4 cycles, done 5 cycles after req.
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h20; wdata = 32'h1122_3344;
        req3 = 1'b1; bc = 0; dc = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            req3 = 1'b0;
            if (busy3) bc++;
            if (done3 && dc < 0) dc = i;
        end
        chk("ws3_busy_cycles", 32'(bc), 32'd4);
        chk("ws3_done_lat", 32'(dc), 32'd5);

        // Back-to-back loads with req held through RESP.
        we = 1'b0; req3 = 1'b1; d1 = -1; d2 = -1; nd = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done3) begin
                nd++;
                if (d1 < 0) d1 = i; else if (d2 < 0) d2 = i;
                chk("b2b_rdata", rdata3, 32'h1122_3344);
            end
            if (i == 10) req3 = 1'b0;
        end
        chk("b2b_first", 32'(d1), 32'd5);
        chk("b2b_second", 32'(d2), 32'd10);
        chk("b2b_count", 32'(nd), 32'd2);

        // Reset in the middle of a store's wait states.
        we = 1'b1; addr = 32'h20; wdata = 32'hDEAD_BEEF; req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy3}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_out", {rdata3[31:3], done3, err3, busy3}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done3) nd++;
        end
        chk("rst_no_done", 32'(nd), 32'd0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
        chk("rst_store_dropped", rd, 32'h1122_3344);
        chk("ws3_access_lat", 32'(lat), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
